// File: rtl/test_seq_pkg.sv
// Shared definitions for the test sequencer: state encodings, phase timer
// width and default phase lengths.
package test_seq_pkg;

  localparam int STATE_W           = 3;
  localparam int PHASE_W           = 8;
  localparam int DEF_RST_CYCLES    = 4;
  localparam int DEF_SETTLE_CYCLES = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_RST     = 3'd1,
    S_RUN     = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/test_sequencer_if.sv
// Control/status bundle between the register wrapper (master) and the
// test sequencer (slave).
interface test_sequencer_if #(
  parameter int WIDTH = 32
);
  import test_seq_pkg::*;

  logic               i_start;
  logic               i_abort;
  logic [WIDTH-1:0]   i_run_len;
  logic [WIDTH-1:0]   i_data_ctr;
  logic [WIDTH-1:0]   i_event_ctr;
  logic               o_tb_reset;
  logic               o_tb_enable;
  logic               o_tb_freeze;
  logic [WIDTH-1:0]   o_data_cap;
  logic [WIDTH-1:0]   o_event_cap;
  logic [WIDTH-1:0]   o_elapsed;
  logic               o_busy;
  logic               o_done;
  logic [STATE_W-1:0] o_state;

  modport master (
    output i_start, i_abort, i_run_len, i_data_ctr, i_event_ctr,
    input  o_tb_reset, o_tb_enable, o_tb_freeze, o_data_cap, o_event_cap,
    input  o_elapsed, o_busy, o_done, o_state
  );

  modport slave (
    input  i_start, i_abort, i_run_len, i_data_ctr, i_event_ctr,
    output o_tb_reset, o_tb_enable, o_tb_freeze, o_data_cap, o_event_cap,
    output o_elapsed, o_busy, o_done, o_state
  );

endinterface

// File: rtl/phase_timer.sv
// 8-bit phase down-counter shared by the RST and SETTLE phases.
// Loaded with (length - 1); the phase ends on the cycle zero is seen.
module phase_timer
  import test_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [PHASE_W-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - PHASE_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/test_sequencer.sv
// Test sequencer: holds the testbench in reset, enables it for a run,
// freezes it to let counters settle across the clk_dut crossing, then
// captures the counters.
//
// state   | meaning
// IDLE    | waiting for start, testbench held in reset
// RST     | testbench reset pulse, RST_CYCLES long
// RUN     | testbench enabled, elapsed counting
// SETTLE  | frozen for SETTLE_CYCLES before sampling counters
// CAPTURE | counters loaded into capture registers
// DONE    | results valid, frozen until next start
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  test_sequencer_if.slave bus
);

  localparam logic [PHASE_W-1:0] RST_LOAD    = PHASE_W'(RST_CYCLES - 1);
  localparam logic [PHASE_W-1:0] SETTLE_LOAD = PHASE_W'(SETTLE_CYCLES - 1);

  state_t             state, next_state;
  logic               timer_load, timer_dec, timer_zero;
  logic [PHASE_W-1:0] timer_val;
  logic               start_run;
  logic [WIDTH-1:0]   run_len_q, elapsed, elapsed_inc;
  logic [WIDTH-1:0]   data_cap, event_cap;

  // elapsed holds at all-ones instead of wrapping.
  assign elapsed_inc = (elapsed == '1) ? elapsed : elapsed + WIDTH'(1);

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and phase timer control; start beats abort in IDLE/DONE,
  // abort beats run-length completion in RUN.
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_val  = RST_LOAD;
    timer_dec  = 1'b0;
    start_run  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          next_state = S_RST;
          timer_load = 1'b1;
          start_run  = 1'b1;
        end
      end
      S_RST: begin
        if (bus.i_abort)     next_state = S_IDLE;
        else if (timer_zero) next_state = S_RUN;
        else                 timer_dec  = 1'b1;
      end
      S_RUN: begin
        if (bus.i_abort || ((run_len_q != '0) && (elapsed_inc == run_len_q))) begin
          next_state = S_SETTLE;
          timer_load = 1'b1;
          timer_val  = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (timer_zero) next_state = S_CAPTURE;
        else            timer_dec  = 1'b1;
      end
      S_CAPTURE: next_state = S_DONE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Run length sampling, elapsed counter and end-of-run capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_len_q <= '0;
      elapsed   <= '0;
      data_cap  <= '0;
      event_cap <= '0;
    end else begin
      if (start_run) begin
        run_len_q <= bus.i_run_len;
        elapsed   <= '0;
      end else if (state == S_RUN) begin
        elapsed   <= elapsed_inc;
      end
      if (state == S_CAPTURE) begin
        data_cap  <= bus.i_data_ctr;
        event_cap <= bus.i_event_ctr;
      end
    end
  end

  assign bus.o_tb_reset  = (state == S_IDLE) || (state == S_RST);
  assign bus.o_tb_enable = (state == S_RUN);
  assign bus.o_tb_freeze = (state == S_SETTLE) || (state == S_CAPTURE) || (state == S_DONE);
  assign bus.o_busy      = (state == S_RST) || (state == S_RUN) ||
                           (state == S_SETTLE) || (state == S_CAPTURE);
  assign bus.o_done      = (state == S_DONE);
  assign bus.o_state     = state;
  assign bus.o_elapsed   = elapsed;
  assign bus.o_data_cap  = data_cap;
  assign bus.o_event_cap = event_cap;

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: width of run length, counter inputs and capture outputs.
REQ-002 Parameter RST_CYCLES, default 4: cycles the testbench reset is held at run start; legal range 1..255.
REQ-003 Parameter SETTLE_CYCLES, default 8: cycles freeze is held before capture, covering the clk_dut crossing; legal range 1..255.
REQ-004 clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  single-cycle request to begin a run.
REQ-007 i_abort  in  1  single-cycle request to end the current run early.
REQ-008 i_run_len  in  WIDTH  enable-phase length in cycles; 0 means run until abort.
REQ-009 i_data_ctr, i_event_ctr  in  WIDTH each  live testbench counters.
REQ-010 o_tb_reset, o_tb_enable, o_tb_freeze  out  1 each  testbench control bits (reset, enable, freeze).
REQ-011 o_data_cap, o_event_cap  out  WIDTH each  counter values captured at end of run.
REQ-012 o_elapsed  out  WIDTH  enable-phase cycles completed in the current or last run.
REQ-013 o_busy, o_done  out  1 each  run in progress; results valid.
REQ-014 o_state  out  3  current FSM state encoding.

Function
REQ-015 The FSM SHALL have states IDLE=0, RST=1, RUN=2, SETTLE=3, CAPTURE=4, DONE=5; other encodings SHALL return to IDLE on the next cycle.
REQ-016 IDLE: o_tb_reset=1, enable=0, freeze=0; i_start moves to RST and samples i_run_len into an internal register.
REQ-017 RST: o_tb_reset=1 for exactly RST_CYCLES cycles, then RUN; o_elapsed SHALL clear on entry.
REQ-018 RUN: o_tb_reset=0, o_tb_enable=1; o_elapsed increments once per cycle and saturates at all-ones.
REQ-019 RUN SHALL exit to SETTLE when o_elapsed reaches the sampled run length (nonzero), so enable is high exactly run_len cycles.
REQ-020 SETTLE: enable=0, freeze=1 for exactly SETTLE_CYCLES cycles, then CAPTURE.
REQ-021 CAPTURE (one cycle): freeze=1; o_data_cap/o_event_cap load i_data_ctr/i_event_ctr; next state DONE.
REQ-022 DONE: freeze=1, enable=0, reset=0, o_done=1; i_start begins a new run (to RST); outputs hold otherwise.
REQ-023 o_busy SHALL be 1 in RST, RUN, SETTLE, CAPTURE and 0 in IDLE and DONE.
REQ-024 i_start SHALL be ignored while o_busy=1; i_run_len changes during a run SHALL have no effect.
REQ-025 i_abort in RST SHALL go to IDLE with captures unchanged and o_done=0.
REQ-026 i_abort in RUN SHALL go to SETTLE (partial run, normal capture); in SETTLE/CAPTURE/IDLE/DONE it is ignored.
REQ-027 i_start and i_abort together in IDLE or DONE: start wins; in RUN: abort wins.
REQ-028 o_done SHALL clear on leaving DONE and on abort from RST.

Reset
REQ-029 On reset low: state IDLE, o_tb_reset=1, enable=0, freeze=0, captures=0, o_elapsed=0, busy=0, done=0, o_state=0, taking effect immediately, independent of clk.
REQ-030 Reset asserted mid-run SHALL abandon the run with no capture; deassertion SHALL resume in IDLE.

Structure
REQ-031 State encodings, default RST_CYCLES/SETTLE_CYCLES values and the o_state width SHALL live in shared package test_seq_pkg.
REQ-032 RST and SETTLE phase timing SHALL use one 8-bit phase down-counter sub-module, phase_timer (load, decrement, zero flag), reused across both phases.
REQ-033 The block is controlled through the existing Avalon register wrapper: start/abort/run_len come from a write register, and status/captures go to read registers.

Verification
REQ-034 Start, run_len=10, counters driven with a cycle count: reset high 4 cycles, enable high exactly 10 cycles, freeze 8 cycles, done=1, o_elapsed=10.
REQ-035 run_len=0, abort after 37 RUN cycles: SETTLE entered next cycle, o_elapsed=37, captures equal counter values at CAPTURE.
REQ-036 Abort on 2nd RST cycle: IDLE next cycle, o_done=0, captures keep prior values (0x0 after reset).
REQ-037 Start pulses during RUN, plus i_run_len changed 10->99: no restart, run still ends after 10 enable cycles.
REQ-038 Reset low for one cycle mid-SETTLE, asynchronous to clk: outputs reach reset values immediately, and the next start runs a full sequence.
REQ-039 Start and abort together in DONE: new run begins (RST), o_done drops next cycle.
